// File: rtl/noc_router_xy.sv
// Five-port XY dimension-ordered mesh router: per-input flit FIFOs, per-output
// round-robin arbitration and a registered valid/ready output stage.
module noc_router_xy #(
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0,
    parameter int DATA_WIDTH = 512,
    parameter int MESH_SIDE  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(MESH_SIDE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*DATA_WIDTH-1:0] in_data,
    input  logic [5*CW-1:0]         in_dest_x,
    input  logic [5*CW-1:0]         in_dest_y,
    input  logic [4:0]              in_s_delta_x,
    input  logic [4:0]              in_s_delta_y,
    input  logic [4:0]              in_valid,
    output logic [4:0]              in_ready,
    output logic [5*DATA_WIDTH-1:0] out_data,
    output logic [5*CW-1:0]         out_dest_x,
    output logic [5*CW-1:0]         out_dest_y,
    output logic [4:0]              out_s_delta_x,
    output logic [4:0]              out_s_delta_y,
    output logic [4:0]              out_valid,
    input  logic [4:0]              out_ready
);
    localparam int NP = 5;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = DATA_WIDTH + 2*CW + 2;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0] P_N = 3'd0, P_E = 3'd1, P_S = 3'd2, P_W = 3'd3, P_L = 3'd4;

    // Flit layout: {data, dest_x, dest_y, s_delta_x, s_delta_y}
    logic [FW-1:0] mem [NP][FIFO_DEPTH];
    logic [FW-1:0] in_flit [NP];
    logic [AW-1:0] wr_ptr [NP];
    logic [AW-1:0] rd_ptr [NP];
    logic [AW:0]   cnt [NP];
    logic [NP-1:0] push, pop;
    logic [NP-1:0] head_vld_p0;
    logic [FW-1:0] head_p0 [NP];
    logic [2:0]    route [NP];
    logic [NP-1:0] load_en, gnt_any;
    logic [2:0]    win [NP];
    logic [2:0]    rr_ptr [NP];
    logic [FW-1:0] out_flit_p1 [NP];
    logic [NP-1:0] out_vld_p1;

    function automatic logic [2:0] route_of(input logic [FW-1:0] f);
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        dx = f[2+CW +: CW];
        dy = f[2 +: CW];
        if (dx != CW'(X_COORD))
            return f[1] ? P_W : P_E;
        else if (dy != CW'(Y_COORD))
            return f[0] ? P_S : P_N;
        return P_L;
    endfunction

    // Stage p0: input FIFO heads and route computation
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_flit[p]     = {in_data[p*DATA_WIDTH +: DATA_WIDTH], in_dest_x[p*CW +: CW],
                              in_dest_y[p*CW +: CW], in_s_delta_x[p], in_s_delta_y[p]};
            in_ready[p]    = rst && (cnt[p] != DEPTH_CNT);
            push[p]        = in_valid[p] && in_ready[p];
            head_vld_p0[p] = (cnt[p] != '0);
            head_p0[p]     = mem[p][rd_ptr[p]];
            route[p]       = route_of(head_p0[p]);
        end
    end

    // Round-robin search begins at rr_ptr, which holds the index after the last winner
    always_comb begin
        int idx;
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            load_en[o] = !out_vld_p1[o] || out_ready[o];
            gnt_any[o] = 1'b0;
            win[o]     = '0;
            for (int k = 0; k < NP; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NP)
                    idx -= NP;
                if (load_en[o] && !gnt_any[o] && head_vld_p0[idx] && route[idx] == 3'(o)) begin
                    gnt_any[o] = 1'b1;
                    win[o]     = 3'(idx);
                end
            end
            if (gnt_any[o])
                pop[win[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                cnt[p]    <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                case ({push[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + 1'b1;
                    2'b01:   cnt[p] <= cnt[p] - 1'b1;
                    default: cnt[p] <= cnt[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (push[p])
                mem[p][wr_ptr[p]] <= in_flit[p];
    end

    // Stage p1: registered outputs, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                out_vld_p1[o]  <= 1'b0;
                out_flit_p1[o] <= '0;
                rr_ptr[o]      <= P_N;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (load_en[o]) begin
                    if (gnt_any[o]) begin
                        out_flit_p1[o] <= head_p0[win[o]];
                        out_vld_p1[o]  <= 1'b1;
                        rr_ptr[o]      <= (win[o] == P_L) ? P_N : win[o] + 3'd1;
                    end else begin
                        out_vld_p1[o]  <= 1'b0;
                    end
                end
            end
        end
    end

    assign out_valid = out_vld_p1;

    for (genvar o = 0; o < NP; o++) begin : g_out
        assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = out_flit_p1[o][2+2*CW +: DATA_WIDTH];
        assign out_dest_x[o*CW +: CW]               = out_flit_p1[o][2+CW +: CW];
        assign out_dest_y[o*CW +: CW]               = out_flit_p1[o][2 +: CW];
        assign out_s_delta_x[o]                     = out_flit_p1[o][1];
        assign out_s_delta_y[o]                     = out_flit_p1[o][0];
    end

endmodule

// File: tb/tb_noc_router_xy.sv
// Directed bench for noc_router_xy at mesh position (1,1) in a 4x4 mesh.
module tb_noc_router_xy;
    localparam int DW = 512;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [5*DW-1:0] in_data;
    logic [5*CW-1:0] in_dest_x, in_dest_y;
    logic [4:0]      in_s_delta_x, in_s_delta_y, in_valid, in_ready;
    logic [5*DW-1:0] out_data;
    logic [5*CW-1:0] out_dest_x, out_dest_y;
    logic [4:0]      out_s_delta_x, out_s_delta_y, out_valid, out_ready;

    int total = 0;
    int passed = 0;

    noc_router_xy #(.X_COORD(1), .Y_COORD(1), .DATA_WIDTH(DW), .MESH_SIDE(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
        .in_s_delta_x(in_s_delta_x), .in_s_delta_y(in_s_delta_y),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
        .out_s_delta_x(out_s_delta_x), .out_s_delta_y(out_s_delta_y),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          in_port;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic        sdx;
        logic        sdy;
        logic [DW-1:0] data;
        int          exp_out;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_flit(input int p, input logic [1:0] dx, input logic [1:0] dy,
                            input logic sdx, input logic sdy, input logic [DW-1:0] d);
        in_data[p*DW +: DW]   = d;
        in_dest_x[p*CW +: CW] = dx;
        in_dest_y[p*CW +: CW] = dy;
        in_s_delta_x[p]       = sdx;
        in_s_delta_y[p]       = sdy;
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [4:0]    exp_v;
        logic [3:0]    nib;
        logic [DW-1:0] held;
        int            accepted;
        int            idx;

        rst = 1'b0;
        in_data = '0; in_dest_x = '0; in_dest_y = '0;
        in_s_delta_x = '0; in_s_delta_y = '0; in_valid = '0;
        out_ready = 5'h1f;

        vt[0] = '{4, 2'd1, 2'd1, 1'b0, 1'b0, {128{4'h5}}, 4};
        vt[1] = '{0, 2'd2, 2'd1, 1'b0, 1'b0, {128{4'h1}}, 1};
        vt[2] = '{1, 2'd0, 2'd1, 1'b1, 1'b0, {128{4'h2}}, 3};
        vt[3] = '{2, 2'd2, 2'd0, 1'b0, 1'b1, {128{4'h3}}, 1};
        vt[4] = '{3, 2'd1, 2'd2, 1'b0, 1'b0, {128{4'h4}}, 0};
        vt[5] = '{4, 2'd1, 2'd0, 1'b0, 1'b1, {128{4'hc}}, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_in_ready", DW'(in_ready), '0);
        check("rst_out_data_or", DW'(|out_data), '0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", DW'(in_ready), DW'(5'h1f));

        // Single-flit routing table
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            set_flit(vt[i].in_port, vt[i].dx, vt[i].dy, vt[i].sdx, vt[i].sdy, vt[i].data);
            in_valid = '0;
            in_valid[vt[i].in_port] = 1'b1;
            @(posedge clk); #1;
            in_valid = '0;
            check($sformatf("v%0d_lat_not_yet", i), DW'(out_valid), '0);
            @(posedge clk); #1;
            exp_v = '0;
            exp_v[vt[i].exp_out] = 1'b1;
            check($sformatf("v%0d_route_valid", i), DW'(out_valid), DW'(exp_v));
            check($sformatf("v%0d_data", i), out_data[vt[i].exp_out*DW +: DW], vt[i].data);
            check($sformatf("v%0d_dest", i),
                  DW'({out_dest_x[vt[i].exp_out*CW +: CW], out_dest_y[vt[i].exp_out*CW +: CW],
                       out_s_delta_x[vt[i].exp_out], out_s_delta_y[vt[i].exp_out]}),
                  DW'({vt[i].dx, vt[i].dy, vt[i].sdx, vt[i].sdy}));
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_clear", i), DW'(out_valid), '0);
            check($sformatf("v%0d_data_hold", i), out_data[vt[i].exp_out*DW +: DW], vt[i].data);
        end

        // Contention: two rounds from all five inputs toward EAST
        do_reset();
        out_ready = 5'h1f;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 5; p++) begin
                nib = 4'(r*5 + p + 1);
                set_flit(p, 2'd2, 2'd1, 1'b0, 1'b0, {128{nib}});
            end
            in_valid = 5'h1f;
            @(posedge clk); #1;
        end
        in_valid = '0;
        for (int k = 0; k < 10; k++) begin
            nib = 4'(k + 1);
            check($sformatf("cont%0d_valid", k), DW'(out_valid), DW'(5'b00010));
            check($sformatf("cont%0d_src", k), out_data[1*DW +: DW], {128{nib}});
            @(posedge clk); #1;
        end
        check("cont_drained", DW'(out_valid), '0);

        // Backpressure on EAST with LOCAL streaming
        out_ready = 5'b11101;
        accepted = 0;
        for (int c = 0; c < 20 && in_ready[4]; c++) begin
            set_flit(4, 2'd2, 2'd1, 1'b0, 1'b0, DW'(accepted + 1));
            in_valid[4] = 1'b1;
            @(posedge clk); #1;
            accepted++;
        end
        in_valid = '0;
        check("bp_accepted", DW'(accepted), DW'(5));
        check("bp_in_ready_low", DW'(in_ready[4]), '0);
        held = out_data[1*DW +: DW];
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", c), DW'(out_valid[1]), DW'(1));
            check($sformatf("bp_hold%0d_data", c), out_data[1*DW +: DW], DW'(1));
        end
        check("bp_stable", out_data[1*DW +: DW], held);
        out_ready = 5'h1f;
        idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (out_valid[1]) begin
                check($sformatf("bp_order%0d", idx), out_data[1*DW +: DW], DW'(idx + 1));
                idx++;
            end
            @(posedge clk); #1;
        end
        check("bp_delivered", DW'(idx), DW'(5));
        check("bp_no_extra", DW'(out_valid), '0);
        check("bp_ready_back", DW'(in_ready), DW'(5'h1f));

        // Reset asserted mid-stream
        out_ready = 5'b11101;
        for (int c = 0; c < 2; c++) begin
            set_flit(4, 2'd2, 2'd1, 1'b0, 1'b0, DW'(c + 100));
            in_valid[4] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = '0;
        check("mid_valid_before", DW'(out_valid), DW'(5'b00010));
        #2 rst = 1'b0;
        #1;
        check("mid_out_valid", DW'(out_valid), '0);
        check("mid_in_ready", DW'(in_ready), '0);
        check("mid_out_data", out_data[1*DW +: DW], '0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 5'h1f;
        repeat (3) @(posedge clk);
        #1;
        check("mid_flushed", DW'(out_valid), '0);
        check("mid_ready_after", DW'(in_ready), DW'(5'h1f));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
